// File: rtl/neighbour_pkg.sv
// Shared definitions for the neighbour window producer and the popcount stage.
package neighbour_pkg;

   localparam int unsigned COLS_DEFAULT = 140;

   // Bit positions inside the neighbour vector.
   localparam int unsigned NB_NW = 7;
   localparam int unsigned NB_N  = 6;
   localparam int unsigned NB_NE = 5;
   localparam int unsigned NB_W  = 4;
   localparam int unsigned NB_E  = 3;
   localparam int unsigned NB_SW = 2;
   localparam int unsigned NB_S  = 1;
   localparam int unsigned NB_SE = 0;

   typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

endpackage

// File: rtl/window_mask.sv
// Zeroes the neighbours that fall outside the grid on the top row and the side columns.
module window_mask
   import neighbour_pkg::*;
(
   input  logic [7:0] taps,
   input  logic       row_first,
   input  logic       col_first,
   input  logic       col_final,
   output logic [7:0] nbrs
);

   always_comb begin
      nbrs = taps;
      if (row_first) begin
         nbrs[NB_NW] = 1'b0;
         nbrs[NB_N]  = 1'b0;
         nbrs[NB_NE] = 1'b0;
      end
      if (col_first) begin
         nbrs[NB_NW] = 1'b0;
         nbrs[NB_W]  = 1'b0;
         nbrs[NB_SW] = 1'b0;
      end
      if (col_final) begin
         nbrs[NB_NE] = 1'b0;
         nbrs[NB_E]  = 1'b0;
         nbrs[NB_SE] = 1'b0;
      end
   end

endmodule

// File: rtl/neighbour_window.sv
// Streams one 3x3 window per grid cell from a two-row line buffer; the bottom row is
// completed by a zero flush of COLS+1 pushes after the last cell.
module neighbour_window
   import neighbour_pkg::*;
#(
   parameter int unsigned COLS  = COLS_DEFAULT,
   parameter int unsigned ROW_W = 8,
   parameter int unsigned COL_W = $clog2(COLS)
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_cell,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_center,
   output logic [7:0]       out_nbrs,
   output logic [ROW_W-1:0] out_row,
   output logic [COL_W-1:0] out_col,
   output logic             out_last
);

   localparam int unsigned SR_W   = 2 * COLS + 3;
   localparam int unsigned FILL_W = $clog2(COLS + 2);
   localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(COLS + 1);
   localparam logic [FILL_W-1:0] FLUSH_LAST = FILL_W'(COLS);
   localparam logic [COL_W-1:0]  COL_MAX    = COL_W'(COLS - 1);

   state_t            state_q, state_d;
   logic [SR_W-1:0]   sr_q, sr_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [FILL_W-1:0] flush_q, flush_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic              live_q;

   logic       out_free, accept, flush_push, push, fill_sat, make_win, final_flush;
   logic       row_first, col_first, col_final;
   logic [7:0] taps, masked;

   always_comb begin
      out_free    = !out_valid || out_ready;
      // live_q holds in_ready low until the first clock after reset release.
      in_ready    = live_q && (state_q != FLUSH) && out_free;
      accept      = in_valid && in_ready;
      flush_push  = (state_q == FLUSH) && out_free;
      push        = accept || flush_push;
      fill_sat    = (fill_q == FILL_MAX);
      make_win    = push && fill_sat;
      final_flush = flush_push && (flush_q == FLUSH_LAST);
      row_first   = (row_q == '0);
      col_first   = (col_q == '0);
      col_final   = (col_q == COL_MAX);
   end

   assign sr_d = push ? {sr_q[SR_W-2:0], accept & in_cell} : sr_q;

   // Taps are taken after the push so the window registers alongside it.
   always_comb begin
      taps        = '0;
      taps[NB_SE] = sr_d[0];
      taps[NB_S]  = sr_d[1];
      taps[NB_SW] = sr_d[2];
      taps[NB_E]  = sr_d[COLS];
      taps[NB_W]  = sr_d[COLS+2];
      taps[NB_NE] = sr_d[2*COLS];
      taps[NB_N]  = sr_d[2*COLS+1];
      taps[NB_NW] = sr_d[2*COLS+2];
   end

   window_mask u_mask (
      .taps      (taps),
      .row_first (row_first),
      .col_first (col_first),
      .col_final (col_final),
      .nbrs      (masked)
   );

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      flush_d = flush_q;
      row_d   = row_q;
      col_d   = col_q;

      // Flush pushes count too, so windows emitted always equals cells accepted.
      if (push && !fill_sat) fill_d = fill_q + FILL_W'(1);

      if (make_win) begin
         if (col_final) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end

      unique case (state_q)
         IDLE, FILL: begin
            if (accept) begin
               if (in_last)                state_d = FLUSH;
               else if (fill_d == FILL_MAX) state_d = STREAM;
               else                        state_d = FILL;
            end
         end
         STREAM: begin
            if (accept && in_last) state_d = FLUSH;
         end
         FLUSH: begin
            if (flush_push) begin
               flush_d = flush_q + FILL_W'(1);
               if (final_flush) begin
                  state_d = IDLE;
                  flush_d = '0;
                  fill_d  = '0;
                  row_d   = '0;
                  col_d   = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q    <= IDLE;
         sr_q       <= '0;
         fill_q     <= '0;
         flush_q    <= '0;
         row_q      <= '0;
         col_q      <= '0;
         live_q     <= 1'b0;
         out_valid  <= 1'b0;
         out_center <= 1'b0;
         out_nbrs   <= '0;
         out_row    <= '0;
         out_col    <= '0;
         out_last   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         fill_q  <= fill_d;
         flush_q <= flush_d;
         row_q   <= row_d;
         col_q   <= col_d;
         live_q  <= 1'b1;
         if (make_win) begin
            out_valid  <= 1'b1;
            out_center <= sr_d[COLS+1];
            out_nbrs   <= masked;
            out_row    <= row_q;
            out_col    <= col_q;
            out_last   <= final_flush;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
